regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 16x16-bit register file and shares it between three requesters (0 = core writeback, 1 = load unit, 2 = debug port) using round-robin arbitration.
- Contains a clear sequencer that zeroes all 16 registers, one per cycle, on command.
- Drives the register file's write, write_select and input-data pins directly from registered outputs.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width
- NUM_REGS, 16, registers zeroed by the clear sequence (2**ADDR_W)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req  in  3  per-requester write request; bit i belongs to requester i
- req_addr  in  3*ADDR_W  packed target addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_data  in  3*DATA_W  packed write data; requester i uses bits [i*DATA_W +: DATA_W]
- gnt  out  3  one-hot, one-cycle acceptance pulse
- clear_start  in  1  single-cycle pulse that starts the clear sequence
- busy  out  1  high while the clear sequence runs
- clear_done  out  1  one-cycle pulse when the clear sequence completes
- rf_write  out  1  register file write enable
- rf_write_select  out  ADDR_W  register file write address
- rf_input  out  DATA_W  register file write data

Behaviour:
- Reset: gnt, rf_write, rf_write_select, rf_input, busy and clear_done are all 0. State = ARB. Round-robin pointer last = 2, so requester 0 has top priority first. Clear counter = 0.
- Reset takes effect at any time, including mid-clear. A clear interrupted by reset produces no clear_done.
- All outputs are registered.
- ARB state, cycle N, clear_start = 0:
  - Eligible set = req with the bit of any requester pulsed in gnt during cycle N removed. This prevents double-granting a request that is still held in the grant cycle.
  - Priority order: last+1, last+2, last (mod 3).
  - If the winner is k: in cycle N+1, gnt[k] = 1, rf_write = 1, rf_write_select = req_addr[k] sampled at N, rf_input = req_data[k] sampled at N. last is updated to k.
  - If no requester is eligible: in cycle N+1, rf_write = 0 and gnt = 0. rf_write_select and rf_input hold their previous values.
- Requester rules: hold req, addr and data stable until gnt is seen. Drop req or present new data in the cycle after gnt. Requests are never dropped by the arbiter; a losing request waits.
- Write latency is exactly 1 cycle from the sampling edge to rf_write.
- ARB state, clear_start = 1 at cycle N (clear takes priority):
  - No grant is issued from cycle N's arbitration; requests stay pending.
  - A write granted from cycle N-1 still completes in cycle N.
  - Transition to CLEAR.
- CLEAR state:
  - busy = 1 from N+1 through the last clear write.
  - Cycles N+1 .. N+16: rf_write = 1, rf_write_select = 0..15 ascending, rf_input = 0, gnt = 0.
  - clear_start received during CLEAR is ignored.
  - After address 15 is written: return to ARB. In cycle N+17, busy = 0 and clear_done = 1.
  - Arbitration resumes on the sample at N+16, so the first post-clear grant can write at N+17.
- The counter is ADDR_W bits wide. Exit is detected at count == NUM_REGS-1, with no wrap back into a second pass.
- gnt is never asserted while busy = 1. At most one gnt bit is set in any cycle.

Test Plan:
- Single request: req=3'b001, addr0=4'd5, data0=16'hBEEF held until gnt. Expect gnt=001 exactly one cycle later, with rf_write=1, rf_write_select=5, rf_input=BEEF in the same cycle, and no second write while req is still high in the gnt cycle.
- Contention: req=3'b111 held continuously with each requester re-presenting after its gnt. Expect the grant order 0, 1, 2, 0, 1, 2, one write per cycle after the first grant, with matching addr/data each cycle.
- Clear: clear_start pulse at cycle N with req=0. Expect rf_write=1, rf_input=0 and addresses 0..15 across cycles N+1..N+16, busy high over that span, and clear_done=1 only at N+17.
- Clear vs request: clear_start and req=3'b010 (addr 3, data 1234) in the same cycle. Expect no gnt during the clear; gnt=010 and a write of 1234 to register 3 at N+17.
- Reset mid-clear: reset asserted at the 8th clear write. Expect all outputs 0 the next cycle, no clear_done, and requester 0 winning the next 3'b111 contention.
- clear_start during CLEAR: pulse at N+5. Expect the sequence unchanged and a single clear_done at N+17.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register file write-port owner: round-robin arbitration between core
// writeback (0), load unit (1) and debug port (2), plus a clear sequencer
// that zeroes every register, one per cycle. All outputs are registered.
//
// Handshake: a requester raises req[i] with req_addr/req_data slice i and
// holds all three stable until it observes gnt[i]. gnt[i] is a one-cycle
// acceptance pulse coinciding with the rf_write of that request. In the gnt
// cycle the request is masked from arbitration, so the requester may drop
// req or present new data from the cycle after gnt without a double write.
module regfile_write_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          req,
  input  logic [3*ADDR_W-1:0] req_addr,
  input  logic [3*DATA_W-1:0] req_data,
  output logic [2:0]          gnt,
  input  logic                clear_start,
  output logic                busy,
  output logic                clear_done,
  output logic                rf_write,
  output logic [ADDR_W-1:0]   rf_write_select,
  output logic [DATA_W-1:0]   rf_input
);

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // state_q is the FSM state, observable for bound checkers.
  state_t              state_q, state_d;
  logic [1:0]          last_q, last_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;

  logic [2:0]          gnt_d;
  logic                rf_write_d;
  logic [ADDR_W-1:0]   sel_d;
  logic [DATA_W-1:0]   input_d;
  logic                busy_d;
  logic                done_d;

  logic [2:0]          elig;
  logic [1:0]          p0, p1, p2;
  logic                win_valid;
  logic [1:0]          win_idx;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;

  // Round-robin pick: search last+1, last+2, last, skipping anyone granted this cycle.
  always_comb begin
    elig      = req & ~gnt;
    p0        = 2'd0;
    p1        = 2'd1;
    p2        = 2'd2;
    win_valid = 1'b0;
    win_idx   = last_q;
    case (last_q)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
    if (elig[p0]) begin
      win_valid = 1'b1;
      win_idx   = p0;
    end else if (elig[p1]) begin
      win_valid = 1'b1;
      win_idx   = p1;
    end else if (elig[p2]) begin
      win_valid = 1'b1;
      win_idx   = p2;
    end
  end

  // Route the winning requester's address and data slice.
  always_comb begin
    win_addr = req_addr[0 +: ADDR_W];
    win_data = req_data[0 +: DATA_W];
    case (win_idx)
      2'd1: begin
        win_addr = req_addr[ADDR_W +: ADDR_W];
        win_data = req_data[DATA_W +: DATA_W];
      end
      2'd2: begin
        win_addr = req_addr[2*ADDR_W +: ADDR_W];
        win_data = req_data[2*DATA_W +: DATA_W];
      end
      default: begin
        win_addr = req_addr[0 +: ADDR_W];
        win_data = req_data[0 +: DATA_W];
      end
    endcase
  end

  // Next-state and next-output logic; address/data hold when nothing is written.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    gnt_d      = 3'b000;
    rf_write_d = 1'b0;
    sel_d      = rf_write_select;
    input_d    = rf_input;
    busy_d     = busy;
    done_d     = 1'b0;
    case (state_q)
      ARB: begin
        if (clear_start) begin
          // Clear wins over arbitration; pending requests simply wait.
          state_d    = CLEAR;
          cnt_d      = '0;
          rf_write_d = 1'b1;
          sel_d      = '0;
          input_d    = '0;
          busy_d     = 1'b1;
        end else if (win_valid) begin
          gnt_d      = 3'b001 << win_idx;
          rf_write_d = 1'b1;
          sel_d      = win_addr;
          input_d    = win_data;
          last_d     = win_idx;
        end
      end
      CLEAR: begin
        if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          // Last register is on the bus now: leave CLEAR and arbitrate on
          // this same edge so a waiting request writes next cycle.
          state_d = ARB;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (win_valid) begin
            gnt_d      = 3'b001 << win_idx;
            rf_write_d = 1'b1;
            sel_d      = win_addr;
            input_d    = win_data;
            last_d     = win_idx;
          end
        end else begin
          cnt_d      = cnt_q + 1'b1;
          rf_write_d = 1'b1;
          sel_d      = cnt_q + 1'b1;
          input_d    = '0;
        end
      end
      default: begin
        state_d = ARB;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ARB;
      last_q          <= 2'd2;
      cnt_q           <= '0;
      gnt             <= 3'b000;
      rf_write        <= 1'b0;
      rf_write_select <= '0;
      rf_input        <= '0;
      busy            <= 1'b0;
      clear_done      <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_q          <= last_d;
      cnt_q           <= cnt_d;
      gnt             <= gnt_d;
      rf_write        <= rf_write_d;
      rf_write_select <= sel_d;
      rf_input        <= input_d;
      busy            <= busy_d;
      clear_done      <= done_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single write, round-robin
// contention, clear sequence, clear vs request, reset mid-clear, re-pulse.
module tb_regfile_write_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic                clk;
  logic                reset;
  logic [2:0]          req;
  logic [3*ADDR_W-1:0] req_addr;
  logic [3*DATA_W-1:0] req_data;
  logic [2:0]          gnt;
  logic                clear_start;
  logic                busy;
  logic                clear_done;
  logic                rf_write;
  logic [ADDR_W-1:0]   rf_write_select;
  logic [DATA_W-1:0]   rf_input;

  // Observed bundle: {gnt, rf_write, rf_write_select, rf_input, busy, clear_done}
  logic [25:0] obs;
  logic [25:0] exp_v;
  assign obs = {gnt, rf_write, rf_write_select, rf_input, busy, clear_done};

  int n_checks;
  int n_fail;

  regfile_write_arbiter #(.DATA_W(16), .ADDR_W(4), .NUM_REGS(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .gnt             (gnt),
    .clear_start     (clear_start),
    .busy            (busy),
    .clear_done      (clear_done),
    .rf_write        (rf_write),
    .rf_write_select (rf_write_select),
    .rf_input        (rf_input)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs and samples land 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    req         = 3'b000;
    clear_start = 1'b0;
    req_addr    = '0;
    req_data    = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Contention stimulus model: what requester k presents for its r-th grant.
  function automatic logic [3:0] c_addr(int k, int r);
    return 4'((r * 3 + k + 1) % 16);
  endfunction

  function automatic logic [15:0] c_data(int k, int r);
    return 16'(16'hA000 + r * 16 + k);
  endfunction

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", obs, 26'd0);
    end
    tick();
    n_checks++;
    if (obs !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", obs, 26'd0);
    end
  endtask

  task automatic test_single();
    do_reset();
    req                = 3'b001;
    req_addr[3:0]      = 4'd5;
    req_data[15:0]     = 16'hBEEF;
    req_addr[7:4]      = 4'd9;
    req_data[31:16]    = 16'h1111;
    tick();
    exp_v = {3'b001, 1'b1, 4'd5, 16'hBEEF, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL single_grant: got %h expected %h", obs, exp_v);
    end
    // req still high in the gnt cycle: must not be written twice
    tick();
    req = 3'b000;
    exp_v = {3'b000, 1'b0, 4'd5, 16'hBEEF, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL single_no_double: got %h expected %h", obs, exp_v);
    end
    tick();
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL single_idle_hold: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_contention();
    int k;
    int r;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      req_addr[i*4 +: 4]   = c_addr(i, 0);
      req_data[i*16 +: 16] = c_data(i, 0);
    end
    req = 3'b111;
    for (int g = 0; g < 6; g++) begin
      tick();
      k = g % 3;
      r = g / 3;
      exp_v = {3'(3'b001 << k), 1'b1, c_addr(k, r), c_data(k, r), 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL contention_grant%0d: got %h expected %h", g, obs, exp_v);
      end
      req_addr[k*4 +: 4]   = c_addr(k, r + 1);
      req_data[k*16 +: 16] = c_data(k, r + 1);
    end
    req = 3'b000;
    tick();
    tick();
    exp_v = {3'b000, 1'b0, c_addr(2, 1), c_data(2, 1), 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL contention_idle: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_clear();
    do_reset();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_v = {3'b000, 1'b1, 4'(i), 16'h0000, 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL clear_write%0d: got %h expected %h", i, obs, exp_v);
      end
      tick();
    end
    exp_v = {3'b000, 1'b0, 4'd15, 16'h0000, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL clear_done: got %h expected %h", obs, exp_v);
    end
    tick();
    exp_v = {3'b000, 1'b0, 4'd15, 16'h0000, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL clear_done_pulse: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_clear_vs_req();
    do_reset();
    req_addr        = {4'd7, 4'd3, 4'd2};
    req_data        = {16'h7777, 16'h1234, 16'h2222};
    req             = 3'b010;
    clear_start     = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_v = {3'b000, 1'b1, 4'(i), 16'h0000, 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL cvr_clear%0d: got %h expected %h", i, obs, exp_v);
      end
      tick();
    end
    exp_v = {3'b010, 1'b1, 4'd3, 16'h1234, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL cvr_grant_after_clear: got %h expected %h", obs, exp_v);
    end
    tick();
    req = 3'b000;
    exp_v = {3'b000, 1'b0, 4'd3, 16'h1234, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL cvr_single_write: got %h expected %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    exp_v = {3'b000, 1'b1, 4'd7, 16'h0000, 1'b1, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL rmc_eighth_write: got %h expected %h", obs, exp_v);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (obs !== 26'd0) begin
      n_fail++;
      $display("FAIL rmc_outputs_zero: got %h expected %h", obs, 26'd0);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (obs !== 26'd0) begin
        n_fail++;
        $display("FAIL rmc_no_done%0d: got %h expected %h", i, obs, 26'd0);
      end
    end
    req_addr = {4'd12, 4'd11, 4'd10};
    req_data = {16'hC0C0, 16'hB0B0, 16'hA0A0};
    req      = 3'b111;
    tick();
    exp_v = {3'b001, 1'b1, 4'd10, 16'hA0A0, 1'b0, 1'b0};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL rmc_first_winner: got %h expected %h", obs, exp_v);
    end
    req = 3'b000;
  endtask

  task automatic test_clear_repulse();
    do_reset();
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_v = {3'b000, 1'b1, 4'(i), 16'h0000, 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL repulse_clear%0d: got %h expected %h", i, obs, exp_v);
      end
      clear_start = (i == 4);
      tick();
    end
    clear_start = 1'b0;
    exp_v = {3'b000, 1'b0, 4'd15, 16'h0000, 1'b0, 1'b1};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL repulse_done: got %h expected %h", obs, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = {3'b000, 1'b0, 4'd15, 16'h0000, 1'b0, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL repulse_single_done%0d: got %h expected %h", i, obs, exp_v);
      end
    end
  endtask

  // Scenario sequence and final report
  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    req         = 3'b000;
    clear_start = 1'b0;
    req_addr    = '0;
    req_data    = '0;
    test_reset();
    test_single();
    test_contention();
    test_clear();
    test_clear_vs_req();
    test_reset_mid_clear();
    test_clear_repulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
